// File: rtl/fft_m1_frame_sequencer_if.sv
// Handshake/control bundle between the frame sequencer and its environment.
// Upstream: en, src_valid -> src_ready. Module1: m1_din_valid out, m1_valid_out in.
// Output tagging: out_first, out_last, out_frame_id. Credits: credit_return in.
// Status: busy, err. Optional SEQ_STATS_EN adds frames_issued/frames_done.
interface fft_m1_frame_sequencer_if;
   logic       en;
   logic       src_valid;
   logic       src_ready;
   logic       m1_din_valid;
   logic       m1_valid_out;
   logic       out_first;
   logic       out_last;
   logic [7:0] out_frame_id;
   logic       credit_return;
   logic       busy;
   logic [1:0] err;
`ifdef SEQ_STATS_EN
   logic [15:0] frames_issued;
   logic [15:0] frames_done;

   modport master (
      output en, src_valid, m1_valid_out, credit_return,
      input  src_ready, m1_din_valid, out_first, out_last, out_frame_id, busy, err,
             frames_issued, frames_done
   );
   modport slave (
      input  en, src_valid, m1_valid_out, credit_return,
      output src_ready, m1_din_valid, out_first, out_last, out_frame_id, busy, err,
             frames_issued, frames_done
   );
`else
   modport master (
      output en, src_valid, m1_valid_out, credit_return,
      input  src_ready, m1_din_valid, out_first, out_last, out_frame_id, busy, err
   );
   modport slave (
      input  en, src_valid, m1_valid_out, credit_return,
      output src_ready, m1_din_valid, out_first, out_last, out_frame_id, busy, err
   );
`endif
endinterface

// File: rtl/fft_m1_frame_sequencer.sv
// Frame sequencer ahead of FFT module1: frames the beat stream into frames of
// FRAME_BEATS beats, gates din_valid, enforces downstream credits and an
// in-flight limit, and tags module1 output beats with first/last/frame id.
// Ports: clk, rstn (synchronous, active-high), bus (slave modport of
// fft_m1_frame_sequencer_if). Optional macro SEQ_STATS_EN adds frame counters.
module fft_m1_frame_sequencer #(
   parameter int unsigned FRAME_BEATS  = 32,
   parameter int unsigned CREDITS      = 2,
   parameter int unsigned GAP_CYCLES   = 0,
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input logic                    clk,
   input logic                    rstn,
   fft_m1_frame_sequencer_if.slave bus
);

   localparam int unsigned CNT_W    = (FRAME_BEATS > 2) ? $clog2(FRAME_BEATS) : 1;
   localparam int unsigned CRD_W    = $clog2(CREDITS + 1);
   localparam int unsigned INF_W    = $clog2(MAX_INFLIGHT + 1);
   localparam int unsigned GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_in_cnt;
   logic [CNT_W-1:0] r_out_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [INF_W-1:0] r_inflight;
   logic [CRD_W-1:0] r_credits;
   logic [7:0]       r_in_id;
   logic [7:0]       r_out_id;
   logic [1:0]       r_err;

   logic w_idle_ok;
   logic w_src_ready;
   logic w_hs;
   logic w_start;
   logic w_in_last;
   logic w_out_beat;
   logic w_out_last;

   // Ready is held low during reset so nothing leaks into module1.
   assign w_idle_ok   = bus.en && (r_credits != '0) && (r_inflight < INF_W'(MAX_INFLIGHT));
   assign w_src_ready = !rstn && ((r_state == ST_RUN) || ((r_state == ST_IDLE) && w_idle_ok));
   assign w_hs        = bus.src_valid && w_src_ready;
   assign w_start     = w_hs && (r_state == ST_IDLE);
   assign w_in_last   = w_hs && (r_state == ST_RUN) && (r_in_cnt == CNT_W'(FRAME_BEATS - 1));

   // Output beats arriving with nothing in flight are ignored (flagged in err[0]).
   assign w_out_beat  = !rstn && bus.m1_valid_out && (r_inflight != '0);
   assign w_out_last  = w_out_beat && (r_out_cnt == CNT_W'(FRAME_BEATS - 1));

   assign bus.src_ready    = w_src_ready;
   assign bus.m1_din_valid = w_hs;
   assign bus.out_first    = w_out_beat && (r_out_cnt == '0);
   assign bus.out_last     = w_out_last;
   assign bus.out_frame_id = r_out_id;
   assign bus.busy         = (r_state != ST_IDLE) || (r_inflight != '0);
   assign bus.err          = r_err;

`ifdef SEQ_STATS_EN
   logic [15:0] r_frames_issued;
   logic [15:0] r_frames_done;
   assign bus.frames_issued = r_frames_issued;
   assign bus.frames_done   = r_frames_done;
`endif

   // Input framing FSM, in-flight tracking, credits and output tagging.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state    <= ST_IDLE;
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_inflight <= '0;
         r_credits  <= CRD_W'(CREDITS);
         r_in_id    <= '0;
         r_out_id   <= '0;
         r_err      <= '0;
`ifdef SEQ_STATS_EN
         r_frames_issued <= '0;
         r_frames_done   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_in_cnt <= CNT_W'(1);
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_in_last) begin
                  r_in_cnt <= '0;
                  r_in_id  <= r_in_id + 8'd1;
                  r_state  <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
               end else if (w_hs) begin
                  r_in_cnt <= r_in_cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
                  r_gap_cnt <= '0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Simultaneous start and retire cancel out.
         case ({w_start, w_out_last})
            2'b10:   r_inflight <= r_inflight + INF_W'(1);
            2'b01:   r_inflight <= r_inflight - INF_W'(1);
            default: ;
         endcase

         // Simultaneous start and credit return cancel out; overflow saturates.
         if (w_start && !bus.credit_return) begin
            r_credits <= r_credits - CRD_W'(1);
         end else if (!w_start && bus.credit_return) begin
            if (r_credits == CRD_W'(CREDITS)) begin
               r_err[1] <= 1'b1;
            end else begin
               r_credits <= r_credits + CRD_W'(1);
            end
         end

         if (w_out_beat) begin
            if (w_out_last) begin
               r_out_cnt <= '0;
               r_out_id  <= r_out_id + 8'd1;
            end else begin
               r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
         end

         if (bus.m1_valid_out && (r_inflight == '0)) begin
            r_err[0] <= 1'b1;
         end

`ifdef SEQ_STATS_EN
         if (w_in_last)  r_frames_issued <= r_frames_issued + 16'd1;
         if (w_out_last) r_frames_done   <= r_frames_done + 16'd1;
`endif
      end
   end

endmodule

// File: tb/tb_fft_m1_frame_sequencer.sv
// Self-checking bench for fft_m1_frame_sequencer. Module1 is modelled as a
// fixed 5-cycle valid delay line; expected output markers are queued by the
// stimulus and checked by an independent monitor.
module tb_fft_m1_frame_sequencer;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   fft_m1_frame_sequencer_if m_if ();
   fft_m1_frame_sequencer_if g_if ();

   fft_m1_frame_sequencer u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (m_if)
   );

   fft_m1_frame_sequencer #(.GAP_CYCLES(3)) u_gap (
      .clk  (clk),
      .rstn (rstn),
      .bus  (g_if)
   );

   typedef struct packed {
      logic       first;
      logic       last;
      logic [7:0] id;
   } mark_t;

   mark_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   logic [4:0] dly     = '0;
   logic       force_v = 1'b0;
   logic       auto_en = 1'b0;
   logic       auto_cr = 1'b0;
   logic       man_cr  = 1'b0;
   int         beat_cnt  = 0;
   int         cyc       = 0;
   int         first_cyc = 0;
   int         last_cyc  = 0;

   assign m_if.m1_valid_out  = dly[4] | force_v;
   assign m_if.credit_return = auto_cr | man_cr;
   assign g_if.m1_valid_out  = 1'b0;
   assign g_if.credit_return = 1'b0;

   // Module1 delay model, automatic credit return and input beat accounting.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rstn) begin
         dly      <= '0;
         beat_cnt <= 0;
         auto_cr  <= 1'b0;
      end else begin
         dly     <= {dly[3:0], m_if.m1_din_valid};
         auto_cr <= auto_en && m_if.out_last && dly[4];
         if (m_if.m1_din_valid) begin
            if (beat_cnt == 0) first_cyc <= cyc;
            last_cyc <= cyc;
            beat_cnt <= beat_cnt + 1;
         end
      end
   end

   // Output-side monitor: every modelled module1 beat must match the queue head.
   always @(negedge clk) begin
      if (!rstn && dly[4]) begin
         mark_t got;
         mark_t e;
         got = {m_if.out_first, m_if.out_last, m_if.out_frame_id};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL marker_unexpected: got %0h with empty queue", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL marker: got first=%0b last=%0b id=%0d, expected first=%0b last=%0b id=%0d",
                        got.first, got.last, got.id, e.first, e.last, e.id);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1 rstn = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int id);
      for (int b = 0; b < 32; b++) begin
         mark_t m;
         m.first = (b == 0);
         m.last  = (b == 31);
         m.id    = 8'(id);
         exp_q.push_back(m);
      end
   endtask

   task automatic wait_beats(input string name, input int n, input int budget);
      int k = 0;
      while (beat_cnt < n && k < budget) begin
         idle(1);
         k++;
      end
      check(name, int'(beat_cnt >= n), 1);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((exp_q.size() != 0 || m_if.busy) && k < 300) begin
         idle(1);
         k++;
      end
      check({name, "_queue"}, exp_q.size(), 0);
      check({name, "_busy"}, int'(m_if.busy), 0);
   endtask

   initial begin
      int bad;
      int rdy;
      int base;
      m_if.en = 1'b0; m_if.src_valid = 1'b0;
      g_if.en = 1'b0; g_if.src_valid = 1'b0;

      // Reset state
      reset_dut();
      @(negedge clk);
      check("rst_src_ready", int'(m_if.src_ready), 0);
      check("rst_din_valid", int'(m_if.m1_din_valid), 0);
      check("rst_busy", int'(m_if.busy), 0);
      check("rst_err", int'(m_if.err), 0);
      check("rst_frame_id", int'(m_if.out_frame_id), 0);

      // Mandatory gap of 3 cycles between frames (second instance)
      g_if.en = 1'b1; g_if.src_valid = 1'b1;
      reset_dut();
      bad = 0; rdy = 0;
      for (int c = 0; c < 80; c++) begin
         logic want;
         @(negedge clk);
         want = (c < 32) || (c >= 35 && c < 67);
         if (g_if.src_ready !== want) bad++;
         if (g_if.src_ready) rdy++;
      end
      check("gap_pattern_mismatches", bad, 0);
      check("gap_ready_cycles", rdy, 64);
      g_if.en = 1'b0; g_if.src_valid = 1'b0;

      // Back-to-back frames with credits returned after each out_last
      reset_dut();
      auto_en = 1'b1;
      push_frame(0); push_frame(1); push_frame(2);
      m_if.en = 1'b1; m_if.src_valid = 1'b1;
      wait_beats("b2b_reach70", 70, 200);
      m_if.en = 1'b0;
      wait_beats("b2b_reach96", 96, 100);
      drain("b2b_drain");
      check("b2b_beats", beat_cnt, 96);
      check("b2b_span", last_cyc - first_cyc, 95);
      check("b2b_ready_low_en0", int'(m_if.src_ready), 0);
`ifdef SEQ_STATS_EN
      check("stats_issued", int'(m_if.frames_issued), 3);
      check("stats_done", int'(m_if.frames_done), 3);
`endif

      // Credit exhaustion, then one returned credit
      m_if.src_valid = 1'b0;
      reset_dut();
      auto_en = 1'b0;
      push_frame(0); push_frame(1);
      m_if.en = 1'b1; m_if.src_valid = 1'b1;
      wait_beats("crd_reach64", 64, 150);
      idle(30);
      check("crd_beats_2frames", beat_cnt, 64);
      @(negedge clk);
      check("crd_ready_low", int'(m_if.src_ready), 0);
      drain("crd_drain1");
      push_frame(2);
      man_cr = 1'b1;
      idle(1);
      man_cr = 1'b0;
      wait_beats("crd_reach96", 96, 100);
      idle(30);
      check("crd_beats_3frames", beat_cnt, 96);
      @(negedge clk);
      check("crd_ready_low2", int'(m_if.src_ready), 0);
      drain("crd_drain2");

      // src_valid hole at beat 10, en drop at beat 20
      m_if.en = 1'b0; m_if.src_valid = 1'b0;
      reset_dut();
      auto_en = 1'b1;
      push_frame(0);
      m_if.en = 1'b1; m_if.src_valid = 1'b1;
      wait_beats("hole_reach10", 10, 50);
      m_if.src_valid = 1'b0;
      idle(5);
      check("hole_no_beats", beat_cnt, 10);
      m_if.src_valid = 1'b1;
      wait_beats("hole_reach20", 20, 50);
      m_if.en = 1'b0;
      wait_beats("hole_reach32", 32, 100);
      idle(20);
      check("hole_beats", beat_cnt, 32);
      check("hole_span", last_cyc - first_cyc, 36);
      @(negedge clk);
      check("hole_ready_low", int'(m_if.src_ready), 0);
      drain("hole_drain");

      // Error cases: stray output beat, credit overflow
      auto_en = 1'b0;
      idle(3);
      force_v = 1'b1;
      @(negedge clk);
      check("stray_first", int'(m_if.out_first), 0);
      check("stray_last", int'(m_if.out_last), 0);
      idle(1);
      force_v = 1'b0;
      @(negedge clk);
      check("err_stray", int'(m_if.err), 1);
      idle(1);
      man_cr = 1'b1;
      idle(1);
      man_cr = 1'b0;
      @(negedge clk);
      check("err_overflow", int'(m_if.err), 3);
      push_frame(1); push_frame(2);
      m_if.en = 1'b1;
      wait_beats("ovf_reach96", 96, 150);
      idle(30);
      check("ovf_credits_saturated", beat_cnt, 96);
      drain("ovf_drain");
      check("err_sticky", int'(m_if.err), 3);

      // Reset mid-frame at beat 15
      push_frame(3);
      man_cr = 1'b1;
      idle(1);
      man_cr = 1'b0;
      base = beat_cnt;
      wait_beats("mid_reach15", base + 15, 50);
      rstn = 1'b1;
      @(negedge clk);
      check("mid_rst_src_ready", int'(m_if.src_ready), 0);
      check("mid_rst_din_valid", int'(m_if.m1_din_valid), 0);
      idle(1);
      check("mid_rst_busy", int'(m_if.busy), 0);
      check("mid_rst_err", int'(m_if.err), 0);
      check("mid_rst_frame_id", int'(m_if.out_frame_id), 0);
      exp_q.delete();
      push_frame(0); push_frame(1);
      rstn = 1'b0;
      wait_beats("post_rst_reach64", 64, 150);
      idle(30);
      check("post_rst_credits", beat_cnt, 64);
      drain("post_rst_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
